eth_hdr_strip: RTL and testbench
================================

// Module: eth_hdr_strip
// PURPOSE
//  Sits directly downstream of mac_filter. Consumes accepted 8-bit AXI-Stream Ethernet frames.
//  Captures the 14-byte header (dst MAC, src MAC, EtherType) and strips it from the stream.
//  Forwards the payload with src MAC / EtherType as sideband, and discards runt frames.
// PARAMETERS
//  CNT_W             16      width of saturating statistics counters
//  ALLOWED_ETHERTYPE 16'h0800 EtherType accepted when ETHERTYPE_FILTER_EN is defined
// PORTS
//  clk           in   1   single clock, all logic on rising edge
//  rst_n         in   1   reset, asynchronous, active-low
//  in_tvalid     in   1   upstream frame byte valid
//  in_tready     out  1   upstream byte accepted when tvalid&tready
//  in_tdata      in   8   frame byte, network order
//  in_tlast      in   1   last byte of frame
//  out_tvalid    out  1   payload byte valid
//  out_tready    in   1   downstream ready
//  out_tdata     out  8   payload byte
//  out_tlast     out  1   last payload byte
//  out_ethertype out  16  EtherType of current frame, {byte12,byte13}
//  out_src_mac   out  48  source MAC of current frame, {byte6..byte11}
//  runt_cnt      out  CNT_W  frames with tlast at byte index <=13, saturating
//  drop_cnt      out  CNT_W  frames dropped by EtherType filter, saturating (0 if filter off)
// BEHAVIOUR
//  - Reset: out_tvalid=0, out_tlast=0, out_tdata=0, out_ethertype=0, out_src_mac=0, counters=0, state=HDR, byte_idx=0.
//  - Reset mid-frame: the partial frame is abandoned with no output tlast. The next accepted byte is byte 0.
//  - States:
//    - HDR: byte_idx counts 0..13 and header bytes are shifted into capture registers.
//      - in_tready=1 in HDR, except while the output stage still holds the previous frame's unaccepted tlast.
//    - HDR exit conditions:
//      - tlast at idx<=13 -> runt_cnt++, stay in HDR, idx=0, nothing emitted.
//      - Byte 13 accepted without tlast -> latch ethertype/src_mac into output sideband -> PAY (or DROP, see filter).
//      - An exactly-14-byte frame is a runt, because it carries no payload.
//    - PAY: each accepted byte goes into a 2-entry skid buffer.
//      - in_tready = skid not full.
//      - tlast accepted -> HDR, idx=0.
//    - DROP: in_tready=1, bytes discarded; tlast -> HDR.
//  - Latency: first payload byte appears on out_* 1 cycle after acceptance; throughput 1 byte/cycle.
//  - Handshake:
//    - AXI-S rules: out_tdata/tlast/sideband held stable while out_tvalid & !out_tready.
//    - Never drop or duplicate a byte under backpressure.
//  - Sideband: out_ethertype/out_src_mac stay constant from the first payload byte until the output tlast handshake.
//    They update only at the next frame's header completion.
//  - Back-to-back: the header of frame N+1 may be absorbed while frame N's tail drains.
//    Sideband for N+1 is held in a shadow register until N's output tlast completes.
//  - Counters saturate at all-ones and do not wrap.
// CONFIGURATION
//  - ETHERTYPE_FILTER_EN defined: at header completion, EtherType != ALLOWED_ETHERTYPE -> DROP state, drop_cnt++ once per frame.
//  - ETHERTYPE_FILTER_EN undefined: every non-runt frame goes to PAY; drop_cnt tied to 0; DROP state absent.
// STRUCTURE
//  - eth_pkg:
//    - ETH_HDR_LEN=14, ETH_TYPE_OFS=12, ETH_SRC_OFS=6.
//    - typedef logic[47:0] mac_addr_t; typedef logic[15:0] ethertype_t.
//    - typedef enum {HDR,PAY,DROP} strip_state_t.
//  - Sub-module axis_skid_buf (DATA_W=9, carrying {tlast,tdata}): 2-entry registered ready/valid buffer.
//  - The FSM, header capture and counters live in eth_hdr_strip.
// TESTING
//  1. Good frame:
//     - Stimulus: DE AD BE EF 12 34 | 00 0A 35 12 34 56 | 08 00 | "Hello", out_tready=1.
//     - Response: out 48 65 6C 6C 6F, tlast on 6F; out_ethertype=0x0800, out_src_mac=0x000A35123456.
//  2. Runt frames:
//     - Stimulus: a 10-byte frame, then a 14-byte frame, each with tlast on its last byte.
//     - Response: no out_tvalid; runt_cnt=2; the following good frame still passes intact.
//  3. Backpressure: frame 1 with out_tready toggling 1,0,1,0... -> exactly 48 65 6C 6C 6F in order, data stable while stalled.
//  4. Back-to-back:
//     - Stimulus: "Hello" frame then "World" frame (EtherType 0x86DD) with no idle cycle between them.
//     - Response: 5+5 bytes; sideband 0x0800 through the first tlast, then 0x86DD.
//  5. Filter (ETHERTYPE_FILTER_EN, ALLOWED=0x0800):
//     - Stimulus: 0x86DD frame, then 0x0800 frame.
//     - Response: first produces no output and drop_cnt=1; second passes.
//     - Without the macro: both pass and drop_cnt=0.
//  6. Reset mid-payload:
//     - Stimulus: assert rst_n=0 after 2 payload bytes.
//     - Response: outputs return to reset values asynchronously; a subsequent full frame is handled correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet header stripper.
//   ETH_HDR_LEN / ETH_TYPE_OFS / ETH_SRC_OFS : header layout, byte offsets
//   mac_addr_t, ethertype_t                  : header field types
//   strip_state_t                            : stripper FSM states (DROP only
//                                              exists when ETHERTYPE_FILTER_EN
//                                              is defined)
package eth_pkg;
    localparam int ETH_HDR_LEN  = 14;
    localparam int ETH_TYPE_OFS = 12;
    localparam int ETH_SRC_OFS  = 6;

    typedef logic [47:0] mac_addr_t;
    typedef logic [15:0] ethertype_t;

    typedef enum logic [1:0] {
        HDR,
        PAY
`ifdef ETHERTYPE_FILTER_EN
        , DROP
`endif
    } strip_state_t;
endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry registered ready/valid buffer.
//   clk, rst_n          : clock, async active-low reset
//   in_valid_i/ready_o  : upstream handshake, in_data_i payload
//   out_valid_o/ready_i : downstream handshake, out_data_o payload
// The head entry drives the outputs straight from a register, so data is
// stable under backpressure. in_ready_o depends only on the fill count,
// never combinationally on out_ready_i.
module axis_skid_buf #(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
    logic              push, pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) head_d = in_data_i;
                else               tail_d = in_data_i;
            end
            2'b01: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd2) head_d = tail_q;
            end
            // push and pop together only happen with one entry held
            2'b11: head_d = in_data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/eth_hdr_strip.sv
// Ethernet header stripper: consumes 8-bit AXI-S frames, removes the 14-byte
// header and forwards the payload with src MAC / EtherType as sideband.
//   clk, rst_n                     : clock, async active-low reset
//   in_tvalid/tready/tdata/tlast   : upstream frame bytes
//   out_tvalid/tready/tdata/tlast  : downstream payload bytes
//   out_ethertype, out_src_mac     : sideband of the frame being output
//   runt_cnt, drop_cnt             : saturating statistics
// Optional macro ETHERTYPE_FILTER_EN: frames whose EtherType differs from
// ALLOWED_ETHERTYPE are discarded and counted in drop_cnt.
module eth_hdr_strip
    import eth_pkg::*;
#(
    parameter int          CNT_W             = 16,
    parameter logic [15:0] ALLOWED_ETHERTYPE = 16'h0800
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic [7:0]       in_tdata,
    input  logic             in_tlast,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [7:0]       out_tdata,
    output logic             out_tlast,
    output logic [15:0]      out_ethertype,
    output logic [47:0]      out_src_mac,
    output logic [CNT_W-1:0] runt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    strip_state_t state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    mac_addr_t    mac_sh_q, out_mac_q, sh_mac_q;
    logic [7:0]   et_hi_q;
    ethertype_t   out_et_q, sh_et_q;
    logic         sb_pend_q;
    logic [1:0]   tl_cnt_q;
    logic [CNT_W-1:0] runt_cnt_q;
    logic         skid_in_valid, skid_in_ready;
    logic [8:0]   skid_out;
    logic         in_acc, hdr_done, runt, push_tl, pop_tl;

    axis_skid_buf #(.DATA_W(9)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (skid_in_valid),
        .in_ready_o (skid_in_ready),
        .in_data_i  ({in_tlast, in_tdata}),
        .out_valid_o(out_tvalid),
        .out_ready_i(out_tready),
        .out_data_o (skid_out)
    );

    assign {out_tlast, out_tdata} = skid_out;
    assign out_ethertype = out_et_q;
    assign out_src_mac   = out_mac_q;
    assign runt_cnt      = runt_cnt_q;
    assign in_acc        = in_tvalid && in_tready;
    assign push_tl       = skid_in_valid && skid_in_ready && in_tlast;
    assign pop_tl        = out_tvalid && out_tready && out_tlast;

`ifdef ETHERTYPE_FILTER_EN
    logic             drop_hit;
    logic [CNT_W-1:0] drop_cnt_q;
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^ALLOWED_ETHERTYPE;
    assign drop_cnt   = '0;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        in_tready     = 1'b0;
        skid_in_valid = 1'b0;
        hdr_done      = 1'b0;
        runt          = 1'b0;
`ifdef ETHERTYPE_FILTER_EN
        drop_hit      = 1'b0;
`endif
        case (state_q)
            HDR: begin
                // Holding off while a tlast sits at the output head keeps at
                // most one frame's sideband waiting in the shadow register.
                in_tready = !(out_tvalid && out_tlast);
                if (in_acc) begin
                    if (in_tlast) begin
                        runt  = 1'b1;
                        idx_d = 4'd0;
                    end else if (idx_q == 4'(ETH_HDR_LEN - 1)) begin
                        idx_d   = 4'd0;
                        state_d = PAY;
`ifdef ETHERTYPE_FILTER_EN
                        if ({et_hi_q, in_tdata} != ALLOWED_ETHERTYPE) begin
                            state_d  = DROP;
                            drop_hit = 1'b1;
                        end else begin
                            hdr_done = 1'b1;
                        end
`else
                        hdr_done = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            PAY: begin
                in_tready     = skid_in_ready;
                skid_in_valid = in_tvalid;
                if (in_tvalid && skid_in_ready && in_tlast) state_d = HDR;
            end
`ifdef ETHERTYPE_FILTER_EN
            DROP: begin
                in_tready = 1'b1;
                if (in_tvalid && in_tlast) state_d = HDR;
            end
`endif
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HDR;
            idx_q      <= 4'd0;
            mac_sh_q   <= '0;
            et_hi_q    <= 8'd0;
            out_et_q   <= '0;
            out_mac_q  <= '0;
            sh_et_q    <= '0;
            sh_mac_q   <= '0;
            sb_pend_q  <= 1'b0;
            tl_cnt_q   <= 2'd0;
            runt_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == HDR && in_acc) begin
                if (idx_q >= 4'(ETH_SRC_OFS) && idx_q < 4'(ETH_TYPE_OFS))
                    mac_sh_q <= {mac_sh_q[39:0], in_tdata};
                if (idx_q == 4'(ETH_TYPE_OFS))
                    et_hi_q <= in_tdata;
            end
            // Number of tlast bytes still inside the output buffer.
            case ({push_tl, pop_tl})
                2'b10:   tl_cnt_q <= tl_cnt_q + 2'd1;
                2'b01:   tl_cnt_q <= tl_cnt_q - 2'd1;
                default: ;
            endcase
            // A header completing while an older frame is still draining parks
            // its sideband until that frame's output tlast handshake.
            if (hdr_done) begin
                if (tl_cnt_q != 2'd0) begin
                    sh_et_q   <= {et_hi_q, in_tdata};
                    sh_mac_q  <= mac_sh_q;
                    sb_pend_q <= 1'b1;
                end else begin
                    out_et_q  <= {et_hi_q, in_tdata};
                    out_mac_q <= mac_sh_q;
                end
            end else if (pop_tl && sb_pend_q) begin
                out_et_q  <= sh_et_q;
                out_mac_q <= sh_mac_q;
                sb_pend_q <= 1'b0;
            end
            if (runt && runt_cnt_q != '1) runt_cnt_q <= runt_cnt_q + 1'b1;
        end
    end

`ifdef ETHERTYPE_FILTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            drop_cnt_q <= '0;
        else if (drop_hit && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
`endif
endmodule

// File: tb/tb_eth_hdr_strip.sv
module tb_eth_hdr_strip;
`ifdef ETHERTYPE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_tvalid, in_tready, in_tlast;
    logic [7:0]  in_tdata;
    logic        out_tvalid, out_tready, out_tlast;
    logic [7:0]  out_tdata;
    logic [15:0] out_ethertype;
    logic [47:0] out_src_mac;
    logic [15:0] runt_cnt, drop_cnt;

    eth_hdr_strip #(.CNT_W(16), .ALLOWED_ETHERTYPE(16'h0800)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tvalid(in_tvalid), .in_tready(in_tready),
        .in_tdata(in_tdata), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tdata(out_tdata), .out_tlast(out_tlast),
        .out_ethertype(out_ethertype), .out_src_mac(out_src_mac),
        .runt_cnt(runt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [15:0] et;
        logic [47:0] mac;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fb[$];
    int         checks = 0;
    int         errors = 0;
    int         rdy_mode = 0;
    int         cyc = 0;
    int         exp_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready pattern: 0 always, 1 toggle, 2 one cycle in 20, 3 never.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        case (rdy_mode)
            0:       out_tready = 1'b1;
            1:       out_tready = ~out_tready;
            2:       out_tready = (cyc % 20 == 0);
            default: out_tready = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on each output handshake and checks that
    // a stalled output holds still.
    exp_t held;
    bit   held_v = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                checks++;
                if (!out_tvalid || out_tdata !== held.d || out_tlast !== held.l ||
                    out_ethertype !== held.et || out_src_mac !== held.mac) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b d=%02h l=%0b et=%04h mac=%012h expected v=1 d=%02h l=%0b et=%04h mac=%012h",
                             out_tvalid, out_tdata, out_tlast, out_ethertype, out_src_mac,
                             held.d, held.l, held.et, held.mac);
                end
            end
            held_v = 0;
            if (out_tvalid && out_tready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got d=%02h l=%0b expected no output", out_tdata, out_tlast);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_tdata !== e.d || out_tlast !== e.l ||
                        out_ethertype !== e.et || out_src_mac !== e.mac) begin
                        errors++;
                        $display("FAIL out_byte: got d=%02h l=%0b et=%04h mac=%012h expected d=%02h l=%0b et=%04h mac=%012h",
                                 out_tdata, out_tlast, out_ethertype, out_src_mac, e.d, e.l, e.et, e.mac);
                    end
                end
            end else if (out_tvalid) begin
                held.d = out_tdata; held.l = out_tlast;
                held.et = out_ethertype; held.mac = out_src_mac;
                held_v = 1;
            end
        end
    end

    task automatic idle(input int n);
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives fb[] byte by byte; tvalid stays high afterwards so frames can be
    // sent back to back.
    task automatic send_fb(input bit with_last);
        for (int i = 0; i < fb.size(); i++) begin
            bit acc = 0;
            int n = 0;
            in_tvalid = 1'b1;
            in_tdata  = fb[i];
            in_tlast  = with_last && (i == fb.size() - 1);
            while (!acc) begin
                @(negedge clk);
                acc = in_tready;
                @(posedge clk);
                #1;
                n++;
                if (!acc && n > 2000) begin
                    errors++;
                    $display("FAIL in_timeout: got tready=0 for %0d cycles expected acceptance", n);
                    in_tvalid = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic expect_fb(input bit pass, input logic [15:0] et, input logic [47:0] mac);
        if (pass) begin
            for (int i = 14; i < fb.size(); i++) begin
                exp_t e;
                e.d = fb[i]; e.l = (i == fb.size() - 1); e.et = et; e.mac = mac;
                sb.push_back(e);
            end
        end
    endtask

    task automatic hello();
        fb = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h00, 8'h0A, 8'h35, 8'h12,
              8'h34, 8'h56, 8'h08, 8'h00, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        expect_fb(1'b1, 16'h0800, 48'h000A35123456);
    endtask

    task automatic world();
        fb = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h02, 8'h11, 8'h22, 8'h33,
              8'h44, 8'h55, 8'h86, 8'hDD, 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
        expect_fb(!FILT, 16'h86DD, 48'h021122334455);
        if (FILT) exp_drop++;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_tvalid = 1'b0; in_tdata = 8'h00; in_tlast = 1'b0; out_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("rst_tdata", 64'(out_tdata), 64'd0);
        chk("rst_tlast", 64'(out_tlast), 64'd0);
        chk("rst_ethertype", 64'(out_ethertype), 64'd0);
        chk("rst_src_mac", 64'(out_src_mac), 64'd0);
        chk("rst_runt_cnt", 64'(runt_cnt), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst_n = 1'b1;
        idle(2);

        // 1. good frame
        hello(); send_fb(1'b1); idle(1);
        drain("t1_drain");

        // 2. runts: 10 bytes, then exactly 14 bytes, then a good frame
        fb = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        send_fb(1'b1);
        fb = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h00, 8'h0A, 8'h35, 8'h12,
              8'h34, 8'h56, 8'h08, 8'h00};
        send_fb(1'b1); idle(3);
        chk("t2_runt_cnt", 64'(runt_cnt), 64'd2);
        chk("t2_no_output", 64'(sb.size()), 64'd0);
        hello(); send_fb(1'b1); idle(1);
        drain("t2_drain");

        // 3. toggling backpressure
        rdy_mode = 1;
        hello(); send_fb(1'b1); idle(1);
        drain("t3_drain");

        // 4. back to back, then again with sparse ready so the next header
        // completes while the previous tail is still waiting
        rdy_mode = 0;
        hello(); send_fb(1'b1);
        world(); send_fb(1'b1); idle(1);
        drain("t4_drain");
        rdy_mode = 2;
        hello(); send_fb(1'b1);
        world(); send_fb(1'b1);
        hello(); send_fb(1'b1); idle(1);
        drain("t4b_drain");
        rdy_mode = 0;

        // 5. EtherType filter
        world(); send_fb(1'b1);
        hello(); send_fb(1'b1); idle(1);
        drain("t5_drain");
        chk("t5_drop_cnt", 64'(drop_cnt), 64'(exp_drop));

        // 6. reset after two payload bytes
        rdy_mode = 3;
        idle(2);
        fb = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h00, 8'h0A, 8'h35, 8'h12,
              8'h34, 8'h56, 8'h08, 8'h00, 8'h48, 8'h65};
        send_fb(1'b0);
        in_tvalid = 1'b0;
        chk("t6_pre_tvalid", 64'(out_tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(out_tvalid), 64'd0);
        chk("t6_rst_tdata", 64'(out_tdata), 64'd0);
        chk("t6_rst_ethertype", 64'(out_ethertype), 64'd0);
        chk("t6_rst_src_mac", 64'(out_src_mac), 64'd0);
        chk("t6_rst_runt_cnt", 64'(runt_cnt), 64'd0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        hello(); send_fb(1'b1); idle(1);
        drain("t6_drain");
        chk("t6_runt_cnt", 64'(runt_cnt), 64'd0);

        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
